btn_debounce_pulse: RTL and testbench
=====================================

// Module: btn_debounce_pulse
// PURPOSE
//  Consumer of a synchronizer's synch_btn output for the digital clock's set/mode buttons.
//  Rejects contact bounce and emits one-cycle press/release strobes.
//  After a long hold, emits auto-repeat strobes for fast time-setting.
//  Sits between the per-button synchronizer and the clock's time-set control FSM.
// PARAMETERS
//  DEBOUNCE_CYCLES  500_000     consecutive stable samples needed to accept a level change (10 ms @ 50 MHz)
//  HOLD_CYCLES      50_000_000  debounced-high cycles before the first auto-repeat strobe (1 s)
//  REPEAT_CYCLES    12_500_000  cycles between subsequent auto-repeat strobes (250 ms)
//  CNT_W            26          counter width; must hold max(param)-1
// PORTS
//  clk            in   1  system clock
//  rst            in   1  asynchronous reset, active-low
//  synch_btn      in   1  already-synchronized raw button level (1 = pressed)
//  btn_level      out  1  debounced button level
//  press_pulse    out  1  1-cycle strobe on accepted press
//  release_pulse  out  1  1-cycle strobe on accepted release
//  repeat_pulse   out  1  1-cycle strobe per auto-repeat tick
//  held           out  1  high while in long-hold (auto-repeat) mode
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, cnt=0, every output 0. All outputs are registered.
//  States and transitions, evaluated per rising clk edge on the current synch_btn sample:
//   IDLE:     synch_btn=1 -> PRESS_WAIT with cnt=1; else stay.
//   PRESS_WAIT: synch_btn=0 -> IDLE with cnt=0 (glitch rejected, no outputs).
//     If synch_btn=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED with cnt=0, btn_level=1, press_pulse=1.
//     Otherwise cnt++.
//   PRESSED:  synch_btn=0 -> RELEASE_WAIT with cnt=1.
//     If synch_btn=1 and cnt==HOLD_CYCLES-1 -> REPEAT with cnt=0, held=1, repeat_pulse=1.
//     Otherwise cnt++.
//   REPEAT:   synch_btn=0 -> RELEASE_WAIT with cnt=1.
//     If synch_btn=1 and cnt==REPEAT_CYCLES-1 -> repeat_pulse=1 with cnt=0.
//     Otherwise cnt++.
//   RELEASE_WAIT: synch_btn=1 -> return to REPEAT if held=1, else PRESSED; cnt=0.
//     Hold/repeat timing restarts on that return.
//     If synch_btn=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE with btn_level=0, held=0, release_pulse=1.
//     Otherwise cnt++.
//  Latency:
//   - press_pulse is high in the cycle after the DEBOUNCE_CYCLES-th consecutive high sample.
//   - release_pulse follows the same rule on consecutive low samples.
//   - The first repeat_pulse comes HOLD_CYCLES cycles after press_pulse.
//   - Each later repeat_pulse comes every REPEAT_CYCLES cycles.
//  Strobes: each pulse is high for exactly 1 cycle. At most one of press/release/repeat is high in any cycle.
//  btn_level stays 1 throughout RELEASE_WAIT. No repeat_pulse is emitted in RELEASE_WAIT.
//  Reset asserted mid-operation: immediate return to IDLE, outputs 0; no release_pulse is emitted.
//  Counter never exceeds its terminal value and does not wrap.
//  Parameter value 1 is legal: acceptance on the first stable sample.
// TESTING  (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3)
//  1 Reset: rst=0 with synch_btn=1 -> all outputs 0. Release rst, hold synch_btn=1 for 4 cycles
//    -> press_pulse high exactly 1 cycle, btn_level=1.
//  2 Bounce reject: pattern 1,1,1,0,1,1,1,0 then steady 0 -> no press_pulse, btn_level stays 0.
//  3 Release: pressed state, then synch_btn=0 for 4 cycles -> release_pulse 1 cycle, btn_level=0.
//    A 2-cycle low glitch instead -> no release_pulse.
//  4 Auto-repeat: hold synch_btn=1 for 30 cycles -> press_pulse at cycle 5, then repeat_pulse at
//    cycles 15, 18, 21, 24, 27, 30; held=1 from cycle 15.
//  5 Glitch while held: in REPEAT, 2-cycle low -> no release; held stays 1; repeat spacing restarts
//    (next repeat_pulse 3 cycles after return).
//  6 Async reset mid-hold: drop rst between clock edges during REPEAT -> outputs 0 immediately,
//    no release_pulse. After release with synch_btn=1 -> new press_pulse after 4 cycles.

Source files
------------

// File: rtl/btn_debounce_pulse.sv
// -----------------------------------------------------------------------------
// btn_debounce_pulse
//
// Debounces one synchronized push-button level for the digital clock's set and
// mode buttons. It produces one-cycle strobes for an accepted press, an accepted
// release, and each auto-repeat tick while the button is held down.
//
// Ports
//   clk            in   system clock
//   rst            in   asynchronous reset, active-low
//   synch_btn      in   synchronized raw button level (1 = pressed)
//   btn_level      out  debounced button level
//   press_pulse    out  1-cycle strobe on accepted press
//   release_pulse  out  1-cycle strobe on accepted release
//   repeat_pulse   out  1-cycle strobe per auto-repeat tick
//   held           out  high while in long-hold (auto-repeat) mode
//   state_dbg      out  current FSM state, for observation only
//
// Handshake: none. Every output is a registered level or strobe. Each strobe is
// high for exactly one clk cycle, and at most one strobe is high in any cycle.
// -----------------------------------------------------------------------------
module btn_debounce_pulse #(
   parameter int DEBOUNCE_CYCLES = 500_000,
   parameter int HOLD_CYCLES     = 50_000_000,
   parameter int REPEAT_CYCLES   = 12_500_000,
   parameter int CNT_W           = 26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       synch_btn,
   output logic       btn_level,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic       repeat_pulse,
   output logic       held,
   output logic [2:0] state_dbg
);

   localparam logic [2:0] IDLE         = 3'd0;
   localparam logic [2:0] PRESS_WAIT   = 3'd1;
   localparam logic [2:0] PRESSED      = 3'd2;
   localparam logic [2:0] REPEAT       = 3'd3;
   localparam logic [2:0] RELEASE_WAIT = 3'd4;

   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   // With a one-sample debounce, the first sample at the new level is already
   // "stable". The FSM then skips the wait states and accepts the change at once.
   localparam bit DEB_ONE = (DEBOUNCE_CYCLES == 1);

   logic [2:0]       state;
   logic [CNT_W-1:0] cnt;

   assign state_dbg = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         cnt           <= '0;
         btn_level     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         repeat_pulse  <= 1'b0;
         held          <= 1'b0;
      end else begin
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         repeat_pulse  <= 1'b0;
         case (state)
            IDLE: begin
               if (synch_btn) begin
                  if (DEB_ONE) begin
                     state       <= PRESSED;
                     cnt         <= '0;
                     btn_level   <= 1'b1;
                     press_pulse <= 1'b1;
                  end else begin
                     state <= PRESS_WAIT;
                     cnt   <= CNT_ONE;
                  end
               end
            end
            PRESS_WAIT: begin
               if (!synch_btn) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == DEB_LAST) begin
                  state       <= PRESSED;
                  cnt         <= '0;
                  btn_level   <= 1'b1;
                  press_pulse <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            PRESSED, REPEAT: begin
               if (!synch_btn) begin
                  if (DEB_ONE) begin
                     state         <= IDLE;
                     cnt           <= '0;
                     btn_level     <= 1'b0;
                     held          <= 1'b0;
                     release_pulse <= 1'b1;
                  end else begin
                     state <= RELEASE_WAIT;
                     cnt   <= CNT_ONE;
                  end
               end else if (state == PRESSED && cnt == HOLD_LAST) begin
                  state        <= REPEAT;
                  cnt          <= '0;
                  held         <= 1'b1;
                  repeat_pulse <= 1'b1;
               end else if (state == REPEAT && cnt == REP_LAST) begin
                  cnt          <= '0;
                  repeat_pulse <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            RELEASE_WAIT: begin
               // A short low glitch returns to the hold state it came from. The
               // counter restarts, so the hold or repeat interval begins again.
               if (synch_btn) begin
                  state <= held ? REPEAT : PRESSED;
                  cnt   <= '0;
               end else if (cnt == DEB_LAST) begin
                  state         <= IDLE;
                  cnt           <= '0;
                  btn_level     <= 1'b0;
                  held          <= 1'b0;
                  release_pulse <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce_pulse
//
// Directed bench for btn_debounce_pulse, run with small timing parameters.
//
// The behavioural model works from two quantities:
//   - the run length of identical input samples, which decides debounced
//     level changes;
//   - the elapsed cycles since the last timing anchor, which decides repeat
//     ticks.
//
// A compare process checks every cycle against that model. Each directed test
// also checks hand-computed literal cycle numbers.
// -----------------------------------------------------------------------------
module tb_btn_debounce_pulse;

   localparam int DEB   = 4;
   localparam int HOLD  = 10;
   localparam int REP   = 3;
   localparam int CNT_W = 8;

   // ---------------- clock / reset ----------------
   logic clk       = 1'b0;
   logic rst       = 1'b0;
   logic synch_btn = 1'b0;

   always #5 clk = ~clk;

   logic       btn_level;
   logic       press_pulse;
   logic       release_pulse;
   logic       repeat_pulse;
   logic       held;
   logic [2:0] state_dbg;

   btn_debounce_pulse #(
      .DEBOUNCE_CYCLES (DEB),
      .HOLD_CYCLES     (HOLD),
      .REPEAT_CYCLES   (REP),
      .CNT_W           (CNT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .synch_btn     (synch_btn),
      .btn_level     (btn_level),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .repeat_pulse  (repeat_pulse),
      .held          (held),
      .state_dbg     (state_dbg)
   );

   // ---------------- scoreboard counters ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // run_len counts consecutive identical samples. The debounced level flips
   // when a run at the opposite level reaches DEB. While the button is
   // debounced high and the input stays high, repeat ticks are measured as
   // elapsed cycles from an anchor. The anchor is set by the press, by the
   // return from a low glitch, or by the previous repeat tick.
   logic m_level   = 1'b0;
   logic m_press   = 1'b0;
   logic m_release = 1'b0;
   logic m_repeat  = 1'b0;
   logic m_held    = 1'b0;
   logic m_prev    = 1'b0;
   int   run_len   = 0;
   int   t_now     = 0;
   int   anchor    = 0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_level = 1'b0; m_press = 1'b0; m_release = 1'b0; m_repeat = 1'b0;
         m_held  = 1'b0; m_prev  = 1'b0; run_len   = 0;    t_now    = 0;
         anchor  = 0;
      end else begin
         t_now     = t_now + 1;
         run_len   = (synch_btn == m_prev) ? run_len + 1 : 1;
         m_press   = 1'b0;
         m_release = 1'b0;
         m_repeat  = 1'b0;
         if (!m_level) begin
            if (synch_btn && run_len == DEB) begin
               m_level = 1'b1; m_press = 1'b1; m_held = 1'b0; anchor = t_now;
            end
         end else if (!synch_btn) begin
            if (run_len == DEB) begin
               m_level = 1'b0; m_held = 1'b0; m_release = 1'b1;
            end
         end else if (!m_prev) begin
            anchor = t_now;
         end else if (!m_held && t_now - anchor == HOLD) begin
            m_repeat = 1'b1; m_held = 1'b1; anchor = t_now;
         end else if (m_held && t_now - anchor == REP) begin
            m_repeat = 1'b1; anchor = t_now;
         end
         m_prev = synch_btn;
      end
   end

   // ---------------- per-cycle compare ----------------
   logic cmp_en = 1'b0;

   always @(negedge clk) begin
      if (cmp_en)
         check("model", int'({btn_level, press_pulse, release_pulse, repeat_pulse, held}),
               int'({m_level, m_press, m_release, m_repeat, m_held}));
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic v, input int n);
      synch_btn = v;
      repeat (n) @(negedge clk);
   endtask

   function automatic bit is_rep_cycle(input int c);
      int rep_cyc[6] = '{15, 18, 21, 24, 27, 30};
      foreach (rep_cyc[k]) if (rep_cyc[k] == c) return 1'b1;
      return 1'b0;
   endfunction

   // ---------------- directed tests ----------------
   initial begin
      // 1: reset with button high, then release reset and press.
      rst       = 1'b0;
      synch_btn = 1'b1;
      repeat (3) @(negedge clk);
      cmp_en = 1'b1;
      check("reset_outputs", int'({btn_level, press_pulse, release_pulse, repeat_pulse, held}), 0);
      rst = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         check("t1_press", int'(press_pulse), int'(i == 4));
         if (i >= 4) check("t1_level", int'(btn_level), 1);
      end
      drive(1'b0, 6);
      check("t1_released", int'(btn_level), 0);

      // 2: bounce rejection.
      begin
         logic [7:0] pat = 8'b1110_1110;
         int presses = 0;
         for (int i = 7; i >= 0; i--) begin
            drive(pat[i], 1);
            presses += int'(press_pulse);
            check("t2_level", int'(btn_level), 0);
         end
         for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1);
            presses += int'(press_pulse);
         end
         check("t2_no_press", presses, 0);
      end

      // 3: 2-cycle glitch rejected, then real release.
      drive(1'b1, 6);
      check("t3_pressed", int'(btn_level), 1);
      begin
         int rel = 0;
         synch_btn = 1'b0;
         for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rel += int'(release_pulse);
         end
         synch_btn = 1'b1;
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rel += int'(release_pulse);
            check("t3_glitch_level", int'(btn_level), 1);
         end
         check("t3_glitch_no_release", rel, 0);
      end
      synch_btn = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         check("t3_release", int'(release_pulse), int'(i == 4));
         check("t3_level", int'(btn_level), int'(i < 4));
      end
      drive(1'b0, 2);

      // 4: auto-repeat. Cycle c is the sample taken after the (c-1)-th high edge.
      synch_btn = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         check("t4_press", int'(press_pulse), int'(i + 1 == 5));
         check("t4_repeat", int'(repeat_pulse), int'(is_rep_cycle(i + 1)));
         check("t4_held", int'(held), int'(i + 1 >= 15));
      end

      // 5: 2-cycle glitch while held. Repeat spacing restarts on return.
      synch_btn = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("t5_low_held", int'(held), 1);
         check("t5_low_no_rel", int'(release_pulse), 0);
         check("t5_low_no_rep", int'(repeat_pulse), 0);
      end
      synch_btn = 1'b1;
      for (int i = 0; i <= 4; i++) begin
         @(negedge clk);
         check("t5_repeat", int'(repeat_pulse), int'(i == 3));
         check("t5_held", int'(held), 1);
         check("t5_level", int'(btn_level), 1);
      end

      // 6: asynchronous reset between clock edges during REPEAT.
      @(posedge clk);
      #2 rst = 1'b0;
      #1 check("t6_async_zero",
               int'({btn_level, press_pulse, release_pulse, repeat_pulse, held}), 0);
      @(negedge clk);
      check("t6_no_release", int'(release_pulse), 0);
      rst = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         check("t6_press", int'(press_pulse), int'(i == 4));
      end
      drive(1'b0, 6);
      check("t6_final_level", int'(btn_level), 0);

      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
